// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the arbiter state encoding.
// The UART register block pulls its response constants from here as well.
package axi4lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLERR  = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_WR_RET   = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RD_RET   = 3'd6
  } arb_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin select. When both requesters are active, the one that
// did not win last time is granted. last_grant resets to 1, so requester 0 wins first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic last_grant;

  always_comb begin
    grant = ~last_grant;
    if (req == 2'b01)      grant = 1'b0;
    else if (req == 2'b10) grant = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_grant <= 1'b1;
    else if (advance) last_grant <= grant;
  end

endmodule

// File: rtl/axi4lite_arbiter.sv
// 2:1 AXI4-Lite arbiter in front of the UART register block. One transaction in
// flight; upstream accept is combinational in IDLE, everything downstream is registered.
//
// state       | meaning
// ST_IDLE     | waiting for a request; accepts it in the same cycle
// ST_WR_ISSUE | driving latched AW/W downstream until both handshakes complete
// ST_WR_WAIT  | bready high, waiting for downstream B
// ST_WR_RET   | presenting B to the granted requester
// ST_RD_ISSUE | driving latched AR downstream
// ST_RD_WAIT  | rready high, waiting for downstream R
// ST_RD_RET   | presenting R to the granted requester
module axi4lite_arbiter
  import axi4lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PROT_WIDTH    = 3,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic [1:0]                 s_axi_awvalid,
  output logic [1:0]                 s_axi_awready,
  input  logic [2*ADDRESS_WIDTH-1:0] s_axi_awaddr,
  input  logic [2*PROT_WIDTH-1:0]    s_axi_awprot,
  input  logic [1:0]                 s_axi_wvalid,
  output logic [1:0]                 s_axi_wready,
  input  logic [2*DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [2*STRB_WIDTH-1:0]    s_axi_wstrb,
  output logic [1:0]                 s_axi_bvalid,
  input  logic [1:0]                 s_axi_bready,
  output logic [3:0]                 s_axi_bresp,
  input  logic [1:0]                 s_axi_arvalid,
  output logic [1:0]                 s_axi_arready,
  input  logic [2*ADDRESS_WIDTH-1:0] s_axi_araddr,
  input  logic [2*PROT_WIDTH-1:0]    s_axi_arprot,
  output logic [1:0]                 s_axi_rvalid,
  input  logic [1:0]                 s_axi_rready,
  output logic [2*DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [3:0]                 s_axi_rresp,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [ADDRESS_WIDTH-1:0]   m_axi_awaddr,
  output logic [PROT_WIDTH-1:0]      m_axi_awprot,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  output logic [DATA_WIDTH-1:0]      m_axi_wdata,
  output logic [STRB_WIDTH-1:0]      m_axi_wstrb,
  input  logic                       m_axi_bvalid,
  input  logic [1:0]                 m_axi_bresp,
  output logic                       m_axi_bready,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  output logic [ADDRESS_WIDTH-1:0]   m_axi_araddr,
  output logic [PROT_WIDTH-1:0]      m_axi_arprot,
  input  logic                       m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  output logic                       m_axi_rready,
  output logic                       grant_id,
  output logic                       busy
);

  arb_state_e state;
  logic [1:0] wr_req, rd_req, req;
  logic       sel, grant_q;
  logic       accept_wr, accept_rd, aw_fin, w_fin;

  assign wr_req = s_axi_awvalid & s_axi_wvalid;
  assign rd_req = s_axi_arvalid;
  assign req    = wr_req | rd_req;

  rr_arb2 u_rr_arb2 (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .req     (req),
    .advance (accept_wr | accept_rd),
    .grant   (sel)
  );

  // Gated by reset so no ready leaks out while the block is held in reset.
  assign accept_wr = s_axi_aresetn && (state == ST_IDLE) && wr_req[sel];
  assign accept_rd = s_axi_aresetn && (state == ST_IDLE) && !wr_req[sel] && rd_req[sel];

  assign s_axi_awready = accept_wr ? onehot2(sel) : 2'b00;
  assign s_axi_wready  = accept_wr ? onehot2(sel) : 2'b00;
  assign s_axi_arready = accept_rd ? onehot2(sel) : 2'b00;

  assign aw_fin   = !m_axi_awvalid || m_axi_awready;
  assign w_fin    = !m_axi_wvalid  || m_axi_wready;
  assign busy     = (state != ST_IDLE);
  assign grant_id = grant_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= ST_IDLE;
      grant_q       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awprot  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arprot  <= '0;
      m_axi_rready  <= 1'b0;
      s_axi_bvalid  <= 2'b00;
      s_axi_bresp   <= '0;
      s_axi_rvalid  <= 2'b00;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_wr) begin
            grant_q       <= sel;
            m_axi_awaddr  <= sel ? s_axi_awaddr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                 : s_axi_awaddr[ADDRESS_WIDTH-1:0];
            m_axi_awprot  <= sel ? s_axi_awprot[2*PROT_WIDTH-1:PROT_WIDTH]
                                 : s_axi_awprot[PROT_WIDTH-1:0];
            m_axi_wdata   <= sel ? s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : s_axi_wdata[DATA_WIDTH-1:0];
            m_axi_wstrb   <= sel ? s_axi_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                                 : s_axi_wstrb[STRB_WIDTH-1:0];
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= ST_WR_ISSUE;
          end else if (accept_rd) begin
            grant_q       <= sel;
            m_axi_araddr  <= sel ? s_axi_araddr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                 : s_axi_araddr[ADDRESS_WIDTH-1:0];
            m_axi_arprot  <= sel ? s_axi_arprot[2*PROT_WIDTH-1:PROT_WIDTH]
                                 : s_axi_arprot[PROT_WIDTH-1:0];
            m_axi_arvalid <= 1'b1;
            state         <= ST_RD_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            s_axi_bvalid <= onehot2(grant_q);
            s_axi_bresp  <= grant_q ? {m_axi_bresp, 2'b00} : {2'b00, m_axi_bresp};
            state        <= ST_WR_RET;
          end
        end
        ST_WR_RET: begin
          if (s_axi_bready[grant_q]) begin
            s_axi_bvalid <= 2'b00;
            s_axi_bresp  <= '0;
            state        <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            s_axi_rvalid <= onehot2(grant_q);
            s_axi_rdata  <= grant_q ? {m_axi_rdata, {DATA_WIDTH{1'b0}}}
                                    : {{DATA_WIDTH{1'b0}}, m_axi_rdata};
            s_axi_rresp  <= grant_q ? {m_axi_rresp, 2'b00} : {2'b00, m_axi_rresp};
            state        <= ST_RD_RET;
          end
        end
        ST_RD_RET: begin
          if (s_axi_rready[grant_q]) begin
            s_axi_rvalid <= 2'b00;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= '0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
